// File: rtl/mask_window_filter_if.sv
// mask_window_filter_if
//   Bundles the pixel stream, filter configuration and filtered output of
//   mask_window_filter.
//   master : stream source / result consumer (drives in_valid, pixel_bit,
//            x_cont, y_cont, mode, thresh; receives out_* and frame stats)
//   slave  : the filter itself
interface mask_window_filter_if #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int SW_BITS = 6,
    parameter int CW      = 19
);
    logic               in_valid;
    logic               pixel_bit;
    logic [XW-1:0]      x_cont;
    logic [YW-1:0]      y_cont;
    logic [1:0]         mode;
    logic [SW_BITS-1:0] thresh;
    logic               out_valid;
    logic               out_pixel;
    logic [XW-1:0]      out_x;
    logic [YW-1:0]      out_y;
    logic               frame_done;
    logic [CW-1:0]      white_count;

    modport master (
        output in_valid, pixel_bit, x_cont, y_cont, mode, thresh,
        input  out_valid, out_pixel, out_x, out_y, frame_done, white_count
    );

    modport slave (
        input  in_valid, pixel_bit, x_cont, y_cont, mode, thresh,
        output out_valid, out_pixel, out_x, out_y, frame_done, white_count
    );
endinterface

// File: rtl/mask_window_filter.sv
// mask_window_filter
//   Binary WIN x WIN window filter on the 1-bit red-classification stream
//   (raster order). Buffers WIN-1 lines, forms the window ending at the
//   current pixel and emits the filtered centre pixel one clock later.
//   Modes: 0 bypass, 1 threshold (sum >= thresh), 2 erode, 3 dilate.
//   Also counts white output pixels per frame.
// Ports:
//   VGA_clock : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : mask_window_filter_if.slave
//               in : in_valid, pixel_bit, x_cont, y_cont, mode, thresh
//               out: out_valid, out_pixel, out_x, out_y, frame_done,
//                    white_count
// WIN must be 3, 5 or 7; 2^SW_BITS > WIN*WIN; 2^CW > H_ACTIVE*V_ACTIVE.
module mask_window_filter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WIN      = 3,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SW_BITS  = 6,
    parameter int CW       = 19
) (
    input  logic                 VGA_clock,
    input  logic                 reset,
    mask_window_filter_if.slave  bus
);
    localparam int H    = (WIN - 1) / 2;
    localparam int TAPS = WIN * WIN;
    localparam int NLB  = WIN - 1;
    localparam int AW   = $clog2(H_ACTIVE);

    // Line buffers and column history carry data only; never reset.
    logic               r_lb   [NLB][H_ACTIVE];
    logic [WIN-1:0]     r_hist [NLB];

    logic [1:0]         r_mode;
    logic [SW_BITS-1:0] r_thr;
    logic               r_vld_p1;
    logic               r_pix_p1;
    logic [XW-1:0]      r_x_p1;
    logic [YW-1:0]      r_y_p1;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      r_wc_p2;
    logic               r_done_p2;

    logic               w_in_ok;
    logic               w_sof;
    logic               w_out_ok;
    logic               w_last;
    logic [AW-1:0]      w_xi;
    logic [WIN-1:0]     w_col;
    logic [WIN-1:0]     w_win [WIN];
    logic [SW_BITS-1:0] w_sum;
    logic               w_pix;

    function automatic logic f_filter(input logic [1:0]         md,
                                      input logic [SW_BITS-1:0] thr,
                                      input logic [SW_BITS-1:0] s,
                                      input logic               centre);
        case (md)
            2'd0:    f_filter = centre;
            2'd1:    f_filter = (s >= thr);
            2'd2:    f_filter = (s == SW_BITS'(TAPS));
            default: f_filter = (s != '0);
        endcase
    endfunction

    assign w_in_ok  = bus.in_valid && (bus.x_cont < XW'(H_ACTIVE))
                                   && (bus.y_cont < YW'(V_ACTIVE));
    assign w_sof    = w_in_ok && (bus.x_cont == '0) && (bus.y_cont == '0);
    assign w_out_ok = w_in_ok && (bus.x_cont >= XW'(H)) && (bus.y_cont >= YW'(H));
    assign w_xi     = bus.x_cont[AW-1:0];

    // Column at x: bit k is line y-k. Lines above the frame are forced to
    // zero from y_cont, so whatever the buffers held before this frame
    // (reset, truncated frame) can never reach the window.
    always_comb begin
        w_col    = '0;
        w_col[0] = bus.pixel_bit;
        for (int k = 1; k < WIN; k++) begin
            w_col[k] = r_lb[k-1][w_xi];
        end
        for (int k = 1; k < WIN; k++) begin
            if (bus.y_cont < YW'(k)) begin
                w_col[k] = 1'b0;
            end
        end
    end

    // Window column j is x-j; columns left of the frame read as zero,
    // which also hides the tail of the previous line left in r_hist.
    always_comb begin
        w_win[0] = w_col;
        for (int j = 1; j < WIN; j++) begin
            w_win[j] = r_hist[j-1];
            if (bus.x_cont < XW'(j)) begin
                w_win[j] = '0;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < WIN; j++) begin
            for (int k = 0; k < WIN; k++) begin
                w_sum = w_sum + SW_BITS'(w_win[j][k]);
            end
        end
    end

    assign w_pix = f_filter(r_mode, r_thr, w_sum, w_win[H][H]);

    // ---- stage p0: line buffer shift chain and column history ----
    always_ff @(posedge VGA_clock) begin
        if (w_in_ok) begin
            r_lb[0][w_xi] <= bus.pixel_bit;
            for (int k = 1; k < NLB; k++) begin
                r_lb[k][w_xi] <= r_lb[k-1][w_xi];
            end
            r_hist[0] <= w_col;
            for (int j = 1; j < NLB; j++) begin
                r_hist[j] <= r_hist[j-1];
            end
        end
    end

    // ---- stage p1: filtered pixel, centre coordinates, frame config ----
    // The shadow mode/thresh only change at the first pixel of a frame, so
    // a frame is always filtered with one consistent setting.
    always_ff @(posedge VGA_clock) begin
        if (reset) begin
            r_mode   <= 2'd0;
            r_thr    <= '0;
            r_vld_p1 <= 1'b0;
            r_pix_p1 <= 1'b0;
            r_x_p1   <= '0;
            r_y_p1   <= '0;
        end else begin
            if (w_sof) begin
                r_mode <= bus.mode;
                r_thr  <= bus.thresh;
            end
            r_vld_p1 <= w_out_ok;
            r_pix_p1 <= w_out_ok & w_pix;
            if (w_out_ok) begin
                r_x_p1 <= bus.x_cont - XW'(H);
                r_y_p1 <= bus.y_cont - YW'(H);
            end
        end
    end

    assign w_last = r_vld_p1 && (r_x_p1 == XW'(H_ACTIVE - 1 - H))
                             && (r_y_p1 == YW'(V_ACTIVE - 1 - H));

    // ---- stage p2: frame statistics ----
    // A new frame start clears the running count; if the previous frame
    // never reached its last pixel, no frame_done is issued for it.
    always_ff @(posedge VGA_clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_wc_p2   <= '0;
            r_done_p2 <= 1'b0;
        end else begin
            r_done_p2 <= w_last;
            if (w_last) begin
                r_wc_p2 <= r_cnt + CW'(r_pix_p1);
                r_cnt   <= '0;
            end else if (w_sof) begin
                r_cnt <= '0;
            end else if (r_vld_p1 && r_pix_p1) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.out_valid   = r_vld_p1;
    assign bus.out_pixel   = r_pix_p1;
    assign bus.out_x       = r_x_p1;
    assign bus.out_y       = r_y_p1;
    assign bus.frame_done  = r_done_p2;
    assign bus.white_count = r_wc_p2;
endmodule
